// File: rtl/rr_arb_tree_lock_pkg.sv
// Shared helpers for the round-robin arbiter slice.
package rr_arb_tree_lock_pkg;

    // Index width that stays at least one bit wide for a single input.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_tree_lock_lzc.sv
// Trailing-zero counter: reports the lowest set bit of vec and whether vec is empty.
module rr_arb_lzc #(
    parameter int unsigned Width    = 8,
    parameter int unsigned CntWidth = 3
) (
    input  logic [Width-1:0]    vec,
    output logic [CntWidth-1:0] cnt,
    output logic                empty
);

    always_comb begin
        cnt   = '0;
        empty = 1'b1;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                cnt   = CntWidth'(i);
                empty = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rr_arb_tree_lock.sv
// Round-robin arbiter of NumIn streams onto one output, with pointer freeze,
// synchronous flush and an optional decision lock for stalled outputs.
module rr_arb_tree_lock
    import rr_arb_tree_lock_pkg::*;
#(
    parameter int unsigned NumIn     = 64,
    parameter int unsigned DataWidth = 32,
    parameter bit          ExtPrio   = 1'b0,
    parameter bit          AxiVldRdy = 1'b0,
    parameter bit          LockIn    = 1'b0,
    parameter bit          FairArb   = 1'b1,
    parameter int unsigned IdxWidth  = idx_width(NumIn)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic [IdxWidth-1:0]             rr_i,
    input  logic                            lock_rr_i,
    input  logic [NumIn-1:0]                req_i,
    output logic [NumIn-1:0]                gnt_o,
    input  logic [NumIn-1:0][DataWidth-1:0] data_i,
    input  logic                            gnt_i,
    output logic                            req_o,
    output logic [DataWidth-1:0]            data_o,
    output logic [IdxWidth-1:0]             idx_o
);

    if (NumIn == 1) begin : g_pass
        logic unused_pass;
        assign unused_pass = ^{clk_i, rst_ni, flush_i, lock_rr_i, rr_i};
        assign req_o  = req_i[0];
        assign gnt_o  = gnt_i;
        assign data_o = data_i[0];
        assign idx_o  = '0;
    end else begin : g_arb
        logic [IdxWidth-1:0] rr_q, rr_d, ptr, win, nxt;
        logic                lock_q, lock_d;
        logic [NumIn-1:0]    req_q, req_eff, mask_ge, mask_gt;
        logic [NumIn-1:0]    req_ge, req_gt;
        logic [IdxWidth-1:0] cnt_ge, cnt_all, cnt_gt;
        logic                emp_ge, emp_all, emp_gt;
        logic                unused_rr;

        assign unused_rr = ^rr_i;
        assign ptr       = ExtPrio ? rr_i : rr_q;
        // While locked, arbitrate on the snapshot so the decision cannot move.
        assign req_eff   = (LockIn && lock_q) ? req_q : req_i;

        for (genvar i = 0; i < int'(NumIn); i++) begin : g_mask
            assign mask_ge[i] = (IdxWidth'(i) >= ptr);
            assign mask_gt[i] = (IdxWidth'(i) > win);
        end

        assign req_ge = req_eff & mask_ge;
        assign req_gt = req_eff & mask_gt;

        rr_arb_lzc #(.Width(NumIn), .CntWidth(IdxWidth)) u_lzc_ge (
            .vec(req_ge), .cnt(cnt_ge), .empty(emp_ge)
        );
        rr_arb_lzc #(.Width(NumIn), .CntWidth(IdxWidth)) u_lzc_all (
            .vec(req_eff), .cnt(cnt_all), .empty(emp_all)
        );
        rr_arb_lzc #(.Width(NumIn), .CntWidth(IdxWidth)) u_lzc_gt (
            .vec(req_gt), .cnt(cnt_gt), .empty(emp_gt)
        );

        // No requester at/after the pointer wraps to the lowest requester.
        assign win    = emp_ge ? cnt_all : cnt_ge;
        assign nxt    = emp_gt ? cnt_all : cnt_gt;
        assign req_o  = ~emp_all;
        assign idx_o  = req_o ? win : ptr;
        assign data_o = data_i[idx_o];

        always_comb begin
            gnt_o        = '0;
            gnt_o[idx_o] = gnt_i & (AxiVldRdy | req_i[idx_o]);
        end

        always_comb begin
            rr_d = rr_q;
            if (req_o && gnt_i && !lock_rr_i) begin
                if (FairArb)
                    rr_d = nxt;
                else
                    rr_d = (rr_q == IdxWidth'(NumIn - 1)) ? '0 : rr_q + IdxWidth'(1);
            end
        end

        assign lock_d = LockIn & req_o & ~gnt_i;

        always_ff @(posedge clk_i) begin
            if (!rst_ni || flush_i) begin
                rr_q   <= '0;
                lock_q <= 1'b0;
                req_q  <= '0;
            end else begin
                rr_q   <= rr_d;
                lock_q <= lock_d;
                if (lock_d && !lock_q)
                    req_q <= req_i;
            end
        end

`ifndef SYNTHESIS
        // A source captured in the lock snapshot must hold its request until granted.
        a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
            (LockIn && lock_q) |-> ((req_q & ~req_i) == '0));
`endif
    end

endmodule

// File: tb/tb_rr_arb_tree_lock.sv
// Bench for rr_arb_tree_lock: vector table, corner sequences, fairness run.
module tb_rr_arb_tree_lock;
    localparam int N  = 7;
    localparam int DW = 32;
    localparam int IW = 3;

    logic               clk = 1'b0, rst_n = 1'b0, flush = 1'b0, lock_rr = 1'b0, gnt_in = 1'b0;
    logic [IW-1:0]      rr = '0;
    logic [N-1:0]       req = '0, gnt_out;
    logic [N-1:0][DW-1:0] data = '0;
    logic               req_out;
    logic [DW-1:0]      data_out;
    logic [IW-1:0]      idx_out;

    always #5 clk = ~clk;

    rr_arb_tree_lock #(
        .NumIn(N), .DataWidth(DW), .ExtPrio(1'b0), .AxiVldRdy(1'b0),
        .LockIn(1'b1), .FairArb(1'b1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rr_i(rr), .lock_rr_i(lock_rr),
        .req_i(req), .gnt_o(gnt_out), .data_i(data), .gnt_i(gnt_in),
        .req_o(req_out), .data_o(data_out), .idx_o(idx_out)
    );

    typedef struct {
        logic [N-1:0]  req;
        logic          gnt, lrr, fl;
        logic [IW-1:0] idx;
        logic          ro;
        logic [N-1:0]  go;
    } vec_t;

    typedef struct {
        logic [IW-1:0] idx;
        logic          ro;
        logic [N-1:0]  go;
        string         nm;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0;
    bit   hold_data = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] r, input logic g, input logic l, input logic f);
        @(negedge clk);
        req = r; gnt_in = g; lock_rr = l; flush = f;
        if (!hold_data)
            for (int i = 0; i < N; i++) data[i] = $urandom();
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.nm, ".idx"},   32'(idx_out), 32'(e.idx));
        chk({e.nm, ".req_o"}, 32'(req_out), 32'(e.ro));
        chk({e.nm, ".gnt_o"}, 32'(gnt_out), 32'(e.go));
        chk({e.nm, ".data"},  data_out,     data[e.idx]);
    endtask

    task automatic step(input logic [N-1:0] r, input logic g, input logic l, input logic f,
                        input logic [IW-1:0] eidx, input logic ero, input logic [N-1:0] ego,
                        input string nm);
        drive(r, g, l, f);
        sb.push_back('{eidx, ero, ego, nm});
        #2;
        check_out();
    endtask

    // Independent reference: cyclic search from the pointer.
    function automatic int m_win(input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return p;
    endfunction

    function automatic int m_next(input int w, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(w + k) % N]) return (w + k) % N;
        return w;
    endfunction

    vec_t tbl[16];
    logic [N-1:0] all = '1;
    int   cnt[N];
    int   mp, w, gap;
    logic l;

    initial begin
        tbl[0]  = '{7'b0000000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 7'b0000000};
        tbl[1]  = '{7'b0000101, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 7'b0000001};
        tbl[2]  = '{7'b0000101, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 7'b0000100};
        tbl[3]  = '{7'b0000101, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 7'b0000001};
        tbl[4]  = '{7'b0000101, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 7'b0000100};
        tbl[5]  = '{7'b1100000, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 7'b0100000};
        tbl[6]  = '{7'b1100000, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1, 7'b0000000};
        tbl[7]  = '{7'b1100001, 1'b1, 1'b0, 1'b0, 3'd6, 1'b1, 7'b1000000};
        tbl[8]  = '{7'b1100001, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 7'b0100000};
        tbl[9]  = '{7'b0000010, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 7'b0000010};
        tbl[10] = '{7'b0000011, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 7'b0000001};
        tbl[11] = '{7'b0000011, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 7'b0000010};
        tbl[12] = '{7'b0010000, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 7'b0010000};
        tbl[13] = '{7'b1111111, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 7'b0000001};
        tbl[14] = '{7'b1111111, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 7'b0000010};
        tbl[15] = '{7'b0000000, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 7'b0000000};

        repeat (3) drive('0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            step(tbl[i].req, tbl[i].gnt, tbl[i].lrr, tbl[i].fl,
                 tbl[i].idx, tbl[i].ro, tbl[i].go, $sformatf("tbl%0d", i));

        // Decision lock: stalled output keeps idx 3 while input 1 joins.
        drive('0, 1'b0, 1'b0, 1'b1);
        hold_data = 1'b1;
        step(7'b0001000, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 7'b0000000, "lock_c0");
        for (int c = 1; c < 5; c++)
            step(7'b0001010, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 7'b0000000, $sformatf("lock_c%0d", c));
        step(7'b0001010, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 7'b0001000, "lock_hs");
        hold_data = 1'b0;
        step(7'b0000010, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 7'b0000010, "lock_next");

        // Pointer freeze.
        drive('0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++)
            step(7'b0000011, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 7'b0000001, $sformatf("lrr_c%0d", c));
        step(7'b0000011, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 7'b0000001, "lrr_drop");
        step(7'b0000011, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 7'b0000010, "lrr_next");

        // Flush once the pointer has reached 5.
        drive('0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++)
            step(all, 1'b1, 1'b0, 1'b0, IW'(c), 1'b1, N'(1) << c, $sformatf("fl_c%0d", c));
        step(all, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 7'b0100000, "fl_pulse");
        step(all, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 7'b0000001, "fl_after");

        // Reset mid-traffic with pointer at 3 and a live lock.
        drive('0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++)
            step(all, 1'b1, 1'b0, 1'b0, IW'(c), 1'b1, N'(1) << c, $sformatf("rst_pre%0d", c));
        step(7'b0100000, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 7'b0000000, "rst_lock");
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (5) drive(all, 1'b1, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(7'b0000000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 7'b0000000, "rst_idle");
        step(7'b0011010, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 7'b0000010, "rst_first");

        // Full-load rotation: idx walks 0..6, 1000 grants each.
        drive('0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 7000; c++) begin
            step(all, 1'b1, 1'b0, 1'b0, IW'(c % N), 1'b1, N'(1) << (c % N), "rot");
            for (int i = 0; i < N; i++) cnt[i] += int'(gnt_out[i]);
        end
        for (int i = 0; i < N; i++) begin
            n_chk++;
            if (cnt[i] < 900 || cnt[i] > 1100) begin
                n_fail++;
                $display("FAIL rot_count%0d: actual %0d required 900..1100", i, cnt[i]);
            end
        end

        // Full load with random pointer-freeze pulses every 4-10 cycles.
        for (int i = 0; i < N; i++) cnt[i] = 0;
        mp  = 0;
        gap = $urandom_range(10, 4);
        for (int c = 0; c < 1400; c++) begin
            l = (gap == 0);
            if (l) gap = $urandom_range(10, 4);
            else   gap--;
            w = m_win(mp, all);
            step(all, 1'b1, l, 1'b0, IW'(w), 1'b1, N'(1) << w, "rot_lrr");
            for (int i = 0; i < N; i++) cnt[i] += int'(gnt_out[i]);
            if (!l) mp = m_next(w, all);
        end
        for (int i = 0; i < N; i++) begin
            n_chk++;
            if (cnt[i] < 60 || cnt[i] > 340) begin
                n_fail++;
                $display("FAIL lrr_count%0d: actual %0d required 60..340", i, cnt[i]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arb_tree_lock.md
Name: rr_arb_tree_lock

Overview:
- Round-robin arbiter for NumIn input streams onto one output stream, built as a log2 tree of 2:1 muxes.
- Has a round-robin priority pointer. The pointer can be frozen externally (lock_rr_i) and cleared synchronously (flush_i).
- Optional decision lock (LockIn) gives AXI-stable output while the output is stalled.
- Used as a shared-resource arbiter in redundancy and interconnect paths.

Parameters:
- NumIn, 64, number of input streams (>=1).
- DataWidth, 32, payload width per stream.
- ExtPrio, 0, 1 = priority pointer taken from rr_i instead of the internal counter.
- AxiVldRdy, 0, 1 = gnt_o[i] not gated by req_i[i] (AXI-style ready may precede valid).
- LockIn, 0, 1 = hold the arbitration decision while req_o=1 and gnt_i=0.
- FairArb, 1, 1 = fair pointer update (next requester after winner); 0 = pointer increments by one.
- IdxWidth, derived, ($clog2(NumIn) if NumIn>1 else 1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, reset synchronous active-low (rst_ni sampled on clk_i rising edge).
- flush_i  in  1  synchronous clear of pointer and lock state.
- rr_i  in  IdxWidth  external priority pointer, used only if ExtPrio=1.
- lock_rr_i  in  1  freezes round-robin pointer update this cycle.
- req_i  in  NumIn  per-input valid.
- gnt_o  out  NumIn  per-input ready.
- data_i  in  NumIn x DataWidth  per-input payload.
- gnt_i  in  1  output ready.
- req_o  out  1  output valid.
- data_o  out  DataWidth  payload of the selected input.
- idx_o  out  IdxWidth  index of the selected input.

Behaviour:
- Outputs are combinational from inputs and state; zero latency from req_i to req_o.
- req_o = OR of the effective request vector.
- Winner = first requesting input at or cyclically after the pointer rr_q (rr_i if ExtPrio). Ties are resolved by tree priority consistent with the pointer.
- data_o = data_i[winner]; idx_o = winner. When no request: data_o = data_i[idx_o], idx_o = tree default (pointer-selected leaf), req_o = 0.
- gnt_o[winner] = gnt_i; all other gnt_o = 0.
  - AxiVldRdy=0: additionally gated by req_i[winner].
  - AxiVldRdy=1: the selected leaf may see gnt without req.
- Pointer update (registered): when req_o & gnt_i & ~lock_rr_i & ~flush_i.
  - FairArb=1: rr_d = next requesting index strictly after the winner (wrap at NumIn-1), else the winner.
  - FairArb=0: rr_d = rr_q+1, wrapping to 0 after NumIn-1 (non-power-of-2 safe).
- Decision lock (LockIn=1):
  - lock_d = req_o & ~gnt_i; req_q captured when lock_d rises.
  - While lock_q, arbitration uses the saved req_q, so the same idx_o is held until the handshake.
  - An input in req_q must keep req_i=1 until granted (protocol requirement on the source; a simulation assertion flags violations).
- Reset (rst_ni=0 at clk edge) or flush_i=1: rr_q=0, lock_q=0, req_q=0. flush_i takes priority over any update in the same cycle.
- lock_rr_i and a handshake in the same cycle: the handshake completes, the pointer holds.
- NumIn=1: pass-through (req_o=req_i, gnt_o=gnt_i, data_o=data_i, idx_o=0); no state.
- Fairness: over any window with k continuously requesting inputs and gnt_i=1, each input is served with throughput 1/k +-0.1, including with random lock_rr_i pulses every 4-10 cycles.
- Data ordering: each (req_i[i] & gnt_o[i]) handshake corresponds one-to-one with an output handshake carrying that data and idx_o=i, in the same cycle.

Decomposition:
- No package needed; IdxWidth and the index/data types are local.
- Natural sub-module: rr_arb_lzc, a leading/trailing-zero counter used to compute the fair next pointer from the masked request vector.

Test Plan:
- NumIn=7, all req_i=1, gnt_i=1 for 7000 cycles -> each gnt_o[i] asserted 1000 times (+-10%); idx_o cycles 0..6.
- req_i=7'b0000101, gnt_i=1 -> grants alternate idx 0,2,0,2; data_o equals data_i of the granted input every cycle.
- LockIn=1, req_i=7'b0001000 then gnt_i=0 for 5 cycles while req_i[1] also rises -> idx_o stays 3 and data_o stays stable until gnt_i=1, then the next grant goes to 1.
- lock_rr_i=1 with inputs 0 and 1 requesting, gnt_i=1 for 3 cycles -> idx_o=0 each cycle (pointer frozen); after lock_rr_i drops, the next grant goes to 1.
- flush_i pulse after the pointer reaches 5, with all inputs requesting -> next cycle idx_o=0.
- Reset low for 5 cycles mid-traffic -> after release, rr_q=0 and no stale lock (first grant is the lowest requesting index).
